// File: rtl/lsu_mem_responder_if.sv
// LSU-to-data-memory handshake bundle: consumer request/response lanes
// plus the single external memory read/write port.
interface lsu_mem_responder_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) ();
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    logic busy;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address,
        input  consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready,
        output busy
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address,
        output consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready,
        input  busy
    );
endinterface

// File: rtl/lsu_mem_responder.sv
// Arbitrates LSU load/store requests onto one data-memory port, one at a time.
// LSU_RESP_ROUND_ROBIN_EN selects round-robin arbitration (default: fixed priority).
module lsu_mem_responder #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) (
    input logic clk,
    input logic reset,
    lsu_mem_responder_if.slave bus
);
    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    localparam logic [2:0] IDLE           = 3'd0;
    localparam logic [2:0] READ_WAITING   = 3'd1;
    localparam logic [2:0] WRITE_WAITING  = 3'd2;
    localparam logic [2:0] READ_RELAYING  = 3'd3;
    localparam logic [2:0] WRITE_RELAYING = 3'd4;

    logic [2:0]                         state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               busy_q, busy_d;
    logic                               mrv_q, mrv_d;
    logic [ADDR_BITS-1:0]               mra_q, mra_d;
    logic                               mwv_q, mwv_d;
    logic [ADDR_BITS-1:0]               mwa_q, mwa_d;
    logic [DATA_BITS-1:0]               mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0]           crr_q, crr_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q, crd_d;
    logic [NUM_CONSUMERS-1:0]           cwr_q, cwr_d;

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] scan_idx;
    logic             found;
    logic             gnt_rd;
    int               scan_c;

`ifdef LSU_RESP_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_q, rr_d;
    assign start = rr_q;
`else
    assign start = '0;
`endif

    // Scan from the start channel; read beats write within a channel.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        gnt_rd   = 1'b0;
        scan_c   = 0;
        scan_idx = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            scan_c   = (int'(start) + k) % NUM_CONSUMERS;
            scan_idx = IDX_W'(scan_c);
            if (!found && (bus.consumer_read_valid[scan_idx] ||
                           bus.consumer_write_valid[scan_idx])) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
                gnt_rd  = bus.consumer_read_valid[scan_idx];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mrv_d   = mrv_q;
        mra_d   = mra_q;
        mwv_d   = mwv_q;
        mwa_d   = mwa_q;
        mwd_d   = mwd_q;
        crr_d   = crr_q;
        crd_d   = crd_q;
        cwr_d   = cwr_q;
`ifdef LSU_RESP_ROUND_ROBIN_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d = gnt_idx;
`ifdef LSU_RESP_ROUND_ROBIN_EN
                    rr_d = (gnt_idx == IDX_W'(NUM_CONSUMERS - 1)) ?
                           '0 : gnt_idx + 1'b1;
`endif
                    if (gnt_rd) begin
                        mrv_d   = 1'b1;
                        mra_d   = bus.consumer_read_address[gnt_idx*ADDR_BITS +: ADDR_BITS];
                        state_d = READ_WAITING;
                    end else begin
                        mwv_d   = 1'b1;
                        mwa_d   = bus.consumer_write_address[gnt_idx*ADDR_BITS +: ADDR_BITS];
                        mwd_d   = bus.consumer_write_data[gnt_idx*DATA_BITS +: DATA_BITS];
                        state_d = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (bus.mem_read_ready) begin
                    mrv_d = 1'b0;
                    crd_d[idx_q*DATA_BITS +: DATA_BITS] = bus.mem_read_data;
                    crr_d[idx_q] = 1'b1;
                    state_d = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (bus.mem_write_ready) begin
                    mwv_d        = 1'b0;
                    cwr_d[idx_q] = 1'b1;
                    state_d      = WRITE_RELAYING;
                end
            end
            // Hold ready until the LSU drops valid so it is not re-granted.
            READ_RELAYING: begin
                if (!bus.consumer_read_valid[idx_q]) begin
                    crr_d[idx_q] = 1'b0;
                    state_d      = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!bus.consumer_write_valid[idx_q]) begin
                    cwr_d[idx_q] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            mrv_q   <= 1'b0;
            mra_q   <= '0;
            mwv_q   <= 1'b0;
            mwa_q   <= '0;
            mwd_q   <= '0;
            crr_q   <= '0;
            crd_q   <= '0;
            cwr_q   <= '0;
`ifdef LSU_RESP_ROUND_ROBIN_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            mrv_q   <= mrv_d;
            mra_q   <= mra_d;
            mwv_q   <= mwv_d;
            mwa_q   <= mwa_d;
            mwd_q   <= mwd_d;
            crr_q   <= crr_d;
            crd_q   <= crd_d;
            cwr_q   <= cwr_d;
`ifdef LSU_RESP_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign bus.mem_read_valid       = mrv_q;
    assign bus.mem_read_address     = mra_q;
    assign bus.mem_write_valid      = mwv_q;
    assign bus.mem_write_address    = mwa_q;
    assign bus.mem_write_data       = mwd_q;
    assign bus.consumer_read_ready  = crr_q;
    assign bus.consumer_read_data   = crd_q;
    assign bus.consumer_write_ready = cwr_q;
    assign bus.busy                 = busy_q;
endmodule
